// File: rtl/otter_fetch_pkg.sv
// Shared fetch-stage types and constants: queue entry layout, NOP encoding, reset vector.
package otter_fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misalign;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Ring buffer of fetched instruction entries with push/pop/flush; head shown combinationally.
module fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fq_entry_t                  entry_i,
  input  logic                       pop_i,
  output fq_entry_t                  head_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fq_entry_t             mem_q [Depth];
  logic [PtrW-1:0]       head_q, tail_q;
  logic [CntW-1:0]       cnt_q;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= entry_i;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop_i) begin
        head_q <= head_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential imem reads into a prefetch queue with credit flow and redirect flush.
// Optional misaligned-redirect trap entry when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_RD_EN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic [24:0] IR_IMM_SRC,
  output logic        IR_VALID,
  input  logic        DEC_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        IR_MISALIGN
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     pc_q, pc_d, issue_pc_q, redirect_pc;
  logic            inflight_q;
  logic [CntW-1:0] count;
  fq_entry_t       head, push_entry;
  logic            pop, issue, push, halt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q, trap_q, misaligned;

  assign misaligned  = |REDIRECT_PC[1:0];
  assign redirect_pc = REDIRECT_PC;
  assign halt        = halt_q;
  // trap_q is only set while halted, so it never coincides with a returning read.
  assign push        = (inflight_q | trap_q) & ~REDIRECT;

  always_comb begin
    push_entry = '{inst: IMEM_DOUT, pc: issue_pc_q, misalign: 1'b0};
    if (trap_q) begin
      push_entry = '{inst: NOP_INSTR, pc: pc_q, misalign: 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q <= 1'b0;
      trap_q <= 1'b0;
    end else if (REDIRECT) begin
      halt_q <= misaligned;
      trap_q <= misaligned;
    end else begin
      trap_q <= 1'b0;
    end
  end

  assign IR_MISALIGN = head.misalign;
`else
  logic unused_bits;

  assign redirect_pc = {REDIRECT_PC[31:2], 2'b00};
  assign halt        = 1'b0;
  assign push        = inflight_q & ~REDIRECT;
  assign push_entry  = '{inst: IMEM_DOUT, pc: issue_pc_q, misalign: 1'b0};
  assign unused_bits = ^{head.misalign, REDIRECT_PC[1:0]};
`endif

  assign IR_VALID = (count != '0);
  assign pop      = IR_VALID & DEC_READY;

  // Credit check: queued + in-flight words, less this cycle's pop, must leave a free slot.
  assign issue = ~RST & ~REDIRECT & ~halt &
                 ((32'(count) + 32'(inflight_q)) < (DEPTH + 32'(pop)));

  always_comb begin
    pc_d = pc_q;
    if (REDIRECT) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      issue_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        issue_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (REDIRECT),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign IMEM_RD_EN = issue;
  assign IMEM_ADDR  = pc_q;
  assign IR         = head.inst;
  assign IR_PC      = head.pc;
  assign IR_IMM_SRC = head.inst[31:7];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-of-PCs reference model, directed and random stimulus.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_rd_en, ir_valid, dec_ready, redirect;
  logic [31:0] imem_addr, imem_dout, ir, ir_pc, redirect_pc;
  logic [24:0] ir_imm_src;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        ir_misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .IMEM_RD_EN  (imem_rd_en),
    .IMEM_ADDR   (imem_addr),
    .IMEM_DOUT   (imem_dout),
    .IR          (ir),
    .IR_PC       (ir_pc),
    .IR_IMM_SRC  (ir_imm_src),
    .IR_VALID    (ir_valid),
    .DEC_READY   (dec_ready),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .IR_MISALIGN (ir_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    if (addr == 32'h0000_0300) return 32'hFE0F_0EE3;
    return 32'hA000_0000 + addr;
  endfunction

  // Synchronous instruction memory; junk on idle cycles exposes unqualified captures.
  always @(posedge clk) begin
    if (imem_rd_en) imem_dout <= data_of(imem_addr);
    else            imem_dout <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: PCs of words sitting in the queue, plus one outstanding read.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc, m_pc;
  bit          chk_rst_vals, seen_valid;
  int          cyc;

  task automatic step(input bit rst_v, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          exp_valid, pop, exp_rd;
    logic [31:0] hd, inst;
    @(negedge clk);
    rst = rst_v; dec_ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    if (rst_v) begin
      check_eq("rd_en_in_reset", 32'(imem_rd_en), 32'd0);
      mq.delete();
      m_infl       = 1'b0;
      m_pc         = RESET_PC;
      chk_rst_vals = 1'b1;
      seen_valid   = 1'b0;
      cyc          = 0;
      return;
    end
    if (chk_rst_vals) begin
      check_eq("ir_after_reset", ir, 32'd0);
      check_eq("ir_pc_after_reset", ir_pc, 32'd0);
      chk_rst_vals = 1'b0;
    end
    exp_valid = (mq.size() != 0);
    pop       = exp_valid && rdy;
    exp_rd    = !redir && ((mq.size() + int'(m_infl) - int'(pop)) < int'(DEPTH));
    check_eq("ir_valid", 32'(ir_valid), 32'(exp_valid));
    check_eq("imem_rd_en", 32'(imem_rd_en), 32'(exp_rd));
    if (exp_rd) check_eq("imem_addr", imem_addr, m_pc);
    if (exp_valid) begin
      hd   = mq[0];
      inst = data_of(hd);
      check_eq("ir_pc", ir_pc, hd);
      check_eq("ir", ir, inst);
      check_eq("ir_imm_src", 32'(ir_imm_src), 32'(inst[31:7]));
      if (hd == 32'h0000_0300) check_eq("imm_fe0f0ee3", 32'(ir_imm_src), 32'h01FC_1E1D);
    end
    if (ir_valid === 1'b1 && !seen_valid) begin
      seen_valid = 1'b1;
      check_eq("first_valid_cycle", 32'(cyc), 32'd2);
    end
    if (redir) seen_valid = 1'b1;
    // Model update for the clock edge that ends this cycle.
    if (pop) void'(mq.pop_front());
    if (redir) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = rpc & ~32'h3;
    end else begin
      if (m_infl) mq.push_back(m_infl_pc);
      m_infl = exp_rd;
      if (exp_rd) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset release, streaming with DEC_READY=1.
    repeat (2) step(1, 0, 0, 0);
    repeat (12) step(0, 1, 0, 0);
    // Backpressure then release.
    repeat (5) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);

    // Redirect while the read of 0x10 is in flight.
    repeat (2) step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0100);
    repeat (6) step(0, 1, 0, 0);

    // Immediate-source field.
    step(0, 1, 1, 32'h0000_02F8);
    repeat (8) step(0, 1, 0, 0);

    // Reset with a full queue.
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);

    // Redirect held over several cycles, then PC wrap.
    step(0, 1, 1, 32'h0000_0400);
    step(0, 0, 1, 32'h0000_0500);
    step(0, 1, 1, 32'h0000_0600);
    repeat (6) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFF8);
    repeat (8) step(0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'h0000_0FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc = rpc & ~32'h3;
`endif
      if ($urandom_range(0, 99) == 0) step(1, 0, 0, 0);
      else step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
